// File: rtl/ce_synth_if.sv
// Control/status bundle for ce_synth: divider and phase settings in,
// clock-enable pulses, slice levels and the fractional clock out.
interface ce_synth_if #(
  parameter int NCH     = 4,
  parameter int DIV_W   = 6,
  parameter int PHACC_W = 32
);
  logic                   enable;
  logic                   sync;
  logic [NCH*DIV_W-1:0]   div;
  logic [NCH*DIV_W-1:0]   phase;
  logic [PHACC_W-1:0]     frac_delta;
  logic                   ready;
  logic [NCH-1:0]         ce;
  logic [NCH-1:0]         slice;
  logic                   frac_ce;
  logic                   frac_clk;

  modport master (
    output enable, sync, div, phase, frac_delta,
    input  ready, ce, slice, frac_ce, frac_clk
  );

  modport slave (
    input  enable, sync, div, phase, frac_delta,
    output ready, ce, slice, frac_ce, frac_clk
  );
endinterface

// File: rtl/ce_synth.sv
// Multi-channel integer clock-enable generator plus a fractional phase
// accumulator, with a fixed start-up delay after reset.
module ce_synth #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 6,
  parameter int INIT_CYCLES = 3,
  parameter int PHACC_W     = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  ce_synth_if.slave  bus
);

  localparam logic [7:0] INIT_LAST = 8'(INIT_CYCLES - 1);

  logic [7:0]         init_cnt;
  logic               ready_r;
  logic [DIV_W-1:0]   cnt       [NCH];
  logic [DIV_W-1:0]   div_act   [NCH];
  logic [DIV_W-1:0]   div_in    [NCH];
  logic [DIV_W-1:0]   eff_phase [NCH];
  logic [NCH-1:0]     wrap;
  logic [NCH-1:0]     fire;
  logic [NCH-1:0]     slice_nxt;
  logic [NCH-1:0]     ce_r;
  logic [NCH-1:0]     slice_r;
  logic [PHACC_W-1:0] acc;
  logic [PHACC_W:0]   acc_sum;
  logic               frac_ce_r;
  logic               frac_clk_r;

  // A phase beyond the period clamps to the last count so the channel still fires once per period.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      logic [DIV_W-1:0] ph;
      ph           = bus.phase[i*DIV_W +: DIV_W];
      div_in[i]    = bus.div[i*DIV_W +: DIV_W];
      eff_phase[i] = (ph < div_act[i]) ? ph : div_act[i];
      wrap[i]      = (cnt[i] == div_act[i]);
      fire[i]      = (cnt[i] == eff_phase[i]);
      slice_nxt[i] = ({cnt[i], 1'b0} < ({1'b0, div_act[i]} + (DIV_W+1)'(1)));
    end
    acc_sum = {1'b0, acc} + {1'b0, bus.frac_delta};
  end

  // Priority: start-up hold, then sync realignment, then counting; enable low only freezes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt   <= '0;
      ready_r    <= 1'b0;
      ce_r       <= '0;
      slice_r    <= '0;
      acc        <= '0;
      frac_ce_r  <= 1'b0;
      frac_clk_r <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= '0;
      end
    end else if (!ready_r) begin
      if (init_cnt == INIT_LAST) ready_r <= 1'b1;
      else                       init_cnt <= init_cnt + 8'd1;
      ce_r       <= '0;
      slice_r    <= '0;
      acc        <= '0;
      frac_ce_r  <= 1'b0;
      frac_clk_r <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= div_in[i];
      end
    end else if (bus.sync) begin
      ce_r       <= '0;
      acc        <= '0;
      frac_ce_r  <= 1'b0;
      frac_clk_r <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= div_in[i];
      end
    end else if (bus.enable) begin
      ce_r       <= fire;
      slice_r    <= slice_nxt;
      acc        <= acc_sum[PHACC_W-1:0];
      frac_ce_r  <= acc_sum[PHACC_W];
      frac_clk_r <= acc_sum[PHACC_W-1];
      for (int i = 0; i < NCH; i++) begin
        if (wrap[i]) begin
          cnt[i]     <= '0;
          div_act[i] <= div_in[i];
        end else begin
          cnt[i]     <= cnt[i] + DIV_W'(1);
        end
      end
    end else begin
      ce_r      <= '0;
      frac_ce_r <= 1'b0;
    end
  end

  assign bus.ready    = ready_r;
  assign bus.ce       = ce_r;
  assign bus.slice    = slice_r;
  assign bus.frac_ce  = frac_ce_r;
  assign bus.frac_clk = frac_clk_r;

endmodule

// File: tb/tb_ce_synth.sv
// Directed bench for ce_synth: channel 0 div3/ph0, 1 div0, 2 div3/ph9,
// 3 div5/ph2, accumulator step 2^30.
module tb_ce_synth;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  ce_synth_if #(.NCH(4), .DIV_W(6), .PHACC_W(32)) bus ();

  ce_synth #(.NCH(4), .DIV_W(6), .INIT_CYCLES(3), .PHACC_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_sync();
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
  endtask

  // Expected {ready, ce[3:0], slice[3:0], frac_ce, frac_clk} after the k-th counting cycle from alignment.
  function automatic logic [10:0] exp_run(int k);
    logic [3:0] c;
    logic [3:0] s;
    c = {(k % 6 == 2), (k % 4 == 3), 1'b1, (k % 4 == 0)};
    s = {(k % 6 < 3), (k % 4 < 2), 1'b1, (k % 4 < 2)};
    return {1'b1, c, s, (k % 4 == 3), ((k % 4 == 1) || (k % 4 == 2))};
  endfunction

  function automatic logic [10:0] observed();
    return {bus.ready, bus.ce, bus.slice, bus.frac_ce, bus.frac_clk};
  endfunction

  task automatic test_reset();
    logic [10:0] o;
    bus.enable     = 1'b1;
    bus.sync       = 1'b0;
    bus.div        = {6'd5, 6'd3, 6'd0, 6'd3};
    bus.phase      = {6'd2, 6'd9, 6'd0, 6'd0};
    bus.frac_delta = 32'h4000_0000;
    #2 reset_n = 1'b0;
    tick();
    tick();
    o = observed();
    n_checks++;
    if (o !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got %b expected %b", o, 11'd0);
    end
  endtask

  task automatic test_startup();
    logic [10:0] o;
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if ({bus.ready, bus.ce} !== {(e == 3), 4'b0000}) begin
        n_fail++;
        $display("[TB] FAIL startup_ready edge %0d: got %b expected %b", e, {bus.ready, bus.ce}, {(e == 3), 4'b0000});
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      o = observed();
      n_checks++;
      if (o !== exp_run(k)) begin
        n_fail++;
        $display("[TB] FAIL startup_run k=%0d: got %b expected %b", k, o, exp_run(k));
      end
    end
  endtask

  task automatic test_boundaries();
    pulse_sync();
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if ({bus.ce[1], bus.slice[1]} !== 2'b11) begin
        n_fail++;
        $display("[TB] FAIL div0_channel k=%0d: got %b expected 11", k, {bus.ce[1], bus.slice[1]});
      end
      n_checks++;
      if (bus.ce[2] !== (k % 4 == 3)) begin
        n_fail++;
        $display("[TB] FAIL phase_clamp k=%0d: got %b expected %b", k, bus.ce[2], (k % 4 == 3));
      end
    end
  endtask

  task automatic test_accumulator();
    pulse_sync();
    for (int k = 0; k < 14; k++) begin
      tick();
      n_checks++;
      if ({bus.frac_ce, bus.frac_clk} !== {(k % 4 == 3), ((k % 4 == 1) || (k % 4 == 2))}) begin
        n_fail++;
        $display("[TB] FAIL accumulator k=%0d: got %b expected %b", k, {bus.frac_ce, bus.frac_clk},
                 {(k % 4 == 3), ((k % 4 == 1) || (k % 4 == 2))});
      end
    end
    bus.frac_delta = 32'd0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if ({bus.frac_ce, bus.frac_clk} !== 2'b01) begin
        n_fail++;
        $display("[TB] FAIL zero_delta k=%0d: got %b expected 01", k, {bus.frac_ce, bus.frac_clk});
      end
    end
    bus.frac_delta = 32'h4000_0000;
  endtask

  task automatic test_mid_period();
    pulse_sync();
    tick();
    n_checks++;
    if (bus.ce[0] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mid_period_first: got %b expected 1", bus.ce[0]);
    end
    bus.div[5:0] = 6'd5;
    for (int t = 1; t <= 16; t++) begin
      tick();
      n_checks++;
      if (bus.ce[0] !== ((t == 4) || (t == 10) || (t == 16))) begin
        n_fail++;
        $display("[TB] FAIL mid_period t=%0d: got %b expected %b", t, bus.ce[0], ((t == 4) || (t == 10) || (t == 16)));
      end
    end
    bus.div[5:0] = 6'd3;
  endtask

  task automatic test_sync();
    logic [10:0] o;
    pulse_sync();
    n_checks++;
    if ({bus.ce, bus.frac_ce} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL sync_edge: got %b expected 00000", {bus.ce, bus.frac_ce});
    end
    tick();
    tick();
    pulse_sync();
    n_checks++;
    if ({bus.ce, bus.frac_ce} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL sync_at_cnt2: got %b expected 00000", {bus.ce, bus.frac_ce});
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      o = observed();
      n_checks++;
      if (o !== exp_run(k)) begin
        n_fail++;
        $display("[TB] FAIL after_sync k=%0d: got %b expected %b", k, o, exp_run(k));
      end
    end
  endtask

  task automatic test_sync_enable_low();
    logic [10:0] o;
    bus.enable = 1'b0;
    pulse_sync();
    bus.enable = 1'b1;
    n_checks++;
    if ({bus.ce, bus.frac_ce} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL sync_enable_low_edge: got %b expected 00000", {bus.ce, bus.frac_ce});
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      o = observed();
      n_checks++;
      if (o !== exp_run(k)) begin
        n_fail++;
        $display("[TB] FAIL sync_enable_low k=%0d: got %b expected %b", k, o, exp_run(k));
      end
    end
  endtask

  task automatic test_enable_hold();
    logic [10:0] o;
    logic [10:0] held;
    held = exp_run(5);
    bus.enable = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      o = observed();
      n_checks++;
      if (o !== {1'b1, 4'b0000, held[5:2], 1'b0, held[0]}) begin
        n_fail++;
        $display("[TB] FAIL enable_hold t=%0d: got %b expected %b", t, o, {1'b1, 4'b0000, held[5:2], 1'b0, held[0]});
      end
    end
    bus.enable = 1'b1;
    for (int k = 6; k < 14; k++) begin
      tick();
      o = observed();
      n_checks++;
      if (o !== exp_run(k)) begin
        n_fail++;
        $display("[TB] FAIL enable_resume k=%0d: got %b expected %b", k, o, exp_run(k));
      end
    end
  endtask

  task automatic test_sync_not_ready();
    logic [10:0] o;
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    reset_n  = 1'b1;
    bus.sync = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if ({bus.ready, bus.ce} !== {(e == 3), 4'b0000}) begin
        n_fail++;
        $display("[TB] FAIL sync_not_ready edge %0d: got %b expected %b", e, {bus.ready, bus.ce}, {(e == 3), 4'b0000});
      end
    end
    bus.sync = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      o = observed();
      n_checks++;
      if (o !== exp_run(k)) begin
        n_fail++;
        $display("[TB] FAIL post_init_run k=%0d: got %b expected %b", k, o, exp_run(k));
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [10:0] o;
    tick();
    #2 reset_n = 1'b0;
    #1;
    o = observed();
    n_checks++;
    if (o !== 11'd0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %b expected %b", o, 11'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (bus.ready !== (e == 3)) begin
        n_fail++;
        $display("[TB] FAIL restart_ready edge %0d: got %b expected %b", e, bus.ready, (e == 3));
      end
    end
    tick();
    n_checks++;
    if (bus.ce !== 4'b0011) begin
      n_fail++;
      $display("[TB] FAIL restart_ce: got %b expected 0011", bus.ce);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_boundaries();
    test_accumulator();
    test_mid_period();
    test_sync();
    test_sync_enable_low();
    test_enable_hold();
    test_sync_not_ready();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ce_synth.md
CE_SYNTH -- requirements
Module: ce_synth

Interface
REQ-001 SHALL have parameter NCH, default 4, number of integer clock-enable channels.
REQ-002 SHALL have parameter DIV_W, default 6, width of each channel divider and phase field.
REQ-003 SHALL have parameter INIT_CYCLES, default 3, post-reset start-up delay in clk cycles (1..255).
REQ-004 SHALL have parameter PHACC_W, default 32, width of the fractional phase accumulator.
REQ-005 SHALL have port clk, input, 1, master clock; every register is clocked on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, advance all counters and the accumulator when high.
REQ-008 SHALL have port sync, input, 1, synchronous realignment of all channels and the accumulator.
REQ-009 SHALL have port div, input, NCH*DIV_W, per-channel period minus one; channel i uses bits [i*DIV_W +: DIV_W].
REQ-010 SHALL have port phase, input, NCH*DIV_W, per-channel counter value at which ce fires.
REQ-011 SHALL have port frac_delta, input, PHACC_W, accumulator increment.
REQ-012 SHALL have port ready, output, 1, start-up delay elapsed.
REQ-013 SHALL have port ce, output, NCH, one-cycle clock-enable pulses.
REQ-014 SHALL have port slice, output, NCH, near-50% duty level per channel.
REQ-015 SHALL have port frac_ce, output, 1, one-cycle pulse on accumulator carry-out.
REQ-016 SHALL have port frac_clk, output, 1, accumulator MSB, for use as a synthesised clock.

Function
REQ-017 SHALL hold ready at 0 for INIT_CYCLES rising edges after reset_n deasserts, then set ready to 1 and keep it at 1 until the next reset.
REQ-018 SHALL, while ready=0, hold all counters and the accumulator at 0, drive ce, slice and frac_ce to 0, and load div_act_i from div every cycle.
REQ-019 SHALL define a counting cycle as one with ready=1, enable=1 and sync=0.
REQ-020 SHALL, in a counting cycle, set cnt_i to 0 when cnt_i equals div_act_i, otherwise increment cnt_i by 1; the channel period is div_act_i+1 cycles.
REQ-021 SHALL load div_act_i from div only on the edge where cnt_i wraps, or on sync; a div change mid-period SHALL NOT alter the current period.
REQ-022 SHALL register ce_i as 1 on the edge ending a counting cycle in which cnt_i equals eff_phase_i, and as 0 otherwise; eff_phase_i is min(phase_i, div_act_i).
REQ-023 SHALL register slice_i as (2*cnt_i < div_act_i+1), evaluated in (DIV_W+1)-bit arithmetic, on each counting cycle; div_act_i=0 SHALL give a constant 1.
REQ-024 SHALL, with div_act_i=0, pulse ce_i on every counting cycle.
REQ-025 SHALL, in a counting cycle, compute {carry, acc} = acc + frac_delta in PHACC_W+1 bits, register frac_ce as carry, and register frac_clk as the new acc MSB.
REQ-026 SHALL, with frac_delta=0, hold frac_ce at 0 and keep acc unchanged.
REQ-027 SHALL, when enable=0 and sync=0 with ready=1, hold every cnt_i, acc, slice and frac_clk, and drive ce and frac_ce to 0.
REQ-028 SHALL, when sync=1 with ready=1 and regardless of enable, set every cnt_i and acc to 0, load every div_act_i from div, and drive ce and frac_ce to 0 on that edge.
REQ-029 SHALL ignore sync while ready=0.
REQ-030 SHALL, in the first counting cycle after sync, behave as at counter value 0.

Reset
REQ-031 SHALL, on reset_n=0, immediately clear ready, ce, slice, frac_ce, frac_clk, all cnt_i, all div_act_i, acc and the init counter to 0, including during operation.
REQ-032 SHALL restart the full INIT_CYCLES delay after every reset release.

Verification
REQ-033 SHALL cover start-up: defaults, div0=3, phase0=0, enable=1, release reset -> ready rises on 3rd edge; ce0 pulses once every 4 cycles, the first pulse on the edge after the first counting cycle; slice0 pattern 1,1,0,0.
REQ-034 SHALL cover the boundaries: div1=0 -> ce1 high every counting cycle, slice1 constant 1; div2=3 with phase2=9 -> ce2 fires at cnt2=3.
REQ-035 SHALL cover a mid-period change: div0 changed 3->5 at cnt0=1 -> current period stays 4 cycles, subsequent periods are 6 cycles.
REQ-036 SHALL cover the accumulator: frac_delta=2^30 (PHACC_W=32) -> frac_ce every 4th counting cycle; frac_clk sequence 0,1,1,0 repeating (period 4, 50% duty).
REQ-037 SHALL cover enable and sync: enable low for 5 cycles -> ce=0 and counters hold, then resume at the held count; sync at cnt0=2 -> cnt0=0 next, ce0 fires after the following counting cycle; sync=1 with enable=0 -> realigned; sync while ready=0 -> no effect.
REQ-038 SHALL cover reset mid-run: assert reset_n=0 between edges -> all outputs 0 without a clock edge; on release, ready rises again after 3 edges.
